// File: rtl/outer_deq_scheduler.sv
// Weighted round-robin dequeue scheduler for the outer QoS queues.
// Optional STRICT_PRIO_Q0_EN makes queue 0 strict priority over WRR.
module outer_deq_scheduler #(
    parameter int         NUM_Q    = 4,
    parameter int         DEPTH_W  = 3,
    parameter logic [2:0] WEIGHT_0 = 3'd4,
    parameter logic [2:0] WEIGHT_1 = 3'd3,
    parameter logic [2:0] WEIGHT_2 = 3'd2,
    parameter logic [2:0] WEIGHT_3 = 3'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_Q*DEPTH_W-1:0] depth_bus,
    input  logic                     out_rdy,
    input  logic                     pkt_done,
    output logic [NUM_Q-1:0]         outer_queue_out,
    output logic                     grant_valid,
    output logic [1:0]               grant_id,
    output logic                     credit_reload
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_POP,
        S_BUSY
    } state_t;

    localparam logic [NUM_Q-1:0] ONE_HOT0 = NUM_Q'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]         r_credit [NUM_Q];
    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_grant_id;
    logic [NUM_Q-1:0]   r_oqo;
    logic               r_grant_valid;
    logic               r_credit_reload;

    logic [2:0]         w_weight [NUM_Q];
    logic [DEPTH_W-1:0] w_depth [NUM_Q];
    logic [NUM_Q-1:0]   w_nonempty;
    logic [NUM_Q-1:0]   w_eligible;
    logic               w_pick_found;
    logic [1:0]         w_pick;
    logic [1:0]         w_idx;
    logic               w_grant;
    logic               w_reload;
    logic [2:0]         w_cur_credit;
    logic [2:0]         w_cred_dec;
    logic               w_rotate;
    logic               w_q0_prio;

    assign w_weight[0] = WEIGHT_0;
    assign w_weight[1] = WEIGHT_1;
    assign w_weight[2] = WEIGHT_2;
    assign w_weight[3] = WEIGHT_3;

    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_q
        assign w_depth[gi]    = depth_bus[gi*DEPTH_W +: DEPTH_W];
        assign w_nonempty[gi] = |w_depth[gi];
        assign w_eligible[gi] = w_nonempty[gi] && (r_credit[gi] != 3'd0);
    end

    // First eligible queue at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = r_rr_ptr;
        w_idx        = r_rr_ptr;
        for (int k = 0; k < NUM_Q; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_pick_found && w_eligible[w_idx]) begin
                w_pick_found = 1'b1;
                w_pick       = w_idx;
            end
        end
`ifdef STRICT_PRIO_Q0_EN
        if (w_nonempty[0]) begin
            w_pick_found = 1'b1;
            w_pick       = 2'd0;
        end
`endif
    end

`ifdef STRICT_PRIO_Q0_EN
    assign w_q0_prio = (r_grant_id == 2'd0);
`else
    assign w_q0_prio = 1'b0;
`endif

    assign w_cur_credit = r_credit[r_grant_id];
    assign w_cred_dec   = (w_cur_credit != 3'd0) ? w_cur_credit - 3'd1 : 3'd0;
    // Hand the turn on once credit is spent or the queue is about to empty.
    assign w_rotate     = (w_cred_dec == 3'd0) ||
                          (w_depth[r_grant_id] == DEPTH_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_reload    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (out_rdy && |w_nonempty) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (w_pick_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_POP;
                end else if (|w_nonempty) begin
                    w_reload    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_POP: begin
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (pkt_done) begin
                    w_state_nxt = out_rdy ? S_ARB : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= 2'd0;
            r_grant_id      <= 2'd0;
            r_oqo           <= '0;
            r_grant_valid   <= 1'b0;
            r_credit_reload <= 1'b0;
            for (int i = 0; i < NUM_Q; i++) begin
                r_credit[i] <= w_weight[i];
            end
        end else begin
            r_state         <= w_state_nxt;
            r_credit_reload <= w_reload;
            r_oqo           <= '0;
            if (w_grant) begin
                r_grant_id    <= w_pick;
                r_oqo         <= ONE_HOT0 << w_pick;
                r_grant_valid <= 1'b1;
            end
            if (r_state == S_BUSY && pkt_done) begin
                r_grant_valid <= 1'b0;
            end
            if (w_reload) begin
                for (int i = 0; i < NUM_Q; i++) begin
                    r_credit[i] <= w_weight[i];
                end
            end
            if (r_state == S_POP && !w_q0_prio) begin
                r_credit[r_grant_id] <= w_cred_dec;
                r_rr_ptr <= w_rotate ? r_grant_id + 2'd1 : r_grant_id;
            end
        end
    end

    assign outer_queue_out = r_oqo;
    assign grant_valid     = r_grant_valid;
    assign grant_id        = r_grant_id;
    assign credit_reload   = r_credit_reload;

endmodule
